// File: rtl/secure_serdes_encryptor.sv
// Serial 2-bit-per-cycle plaintext/key loader with byte cipher and sticky done.
// Optional serial cipher output is enabled by defining SERIAL_TX_EN.
module secure_serdes_encryptor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ENC,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ser_bit;

  logic       start;
  logic [7:0] x_w;
  logic [15:0] rot_w;
  logic [7:0] cipher;

  assign start = ui_in[0];

  // Rotate via a doubled copy; upper byte is the left rotation.
  always_comb begin
    x_w    = a_q ^ b_q;
    rot_w  = {x_w, x_w} << b_q[2:0];
    cipher = rot_w[15:8] + b_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;
    busy_d  = busy_q;
    if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_SHIFT;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        S_SHIFT: begin
          a_d   = {a_q[6:0], ui_in[1]};
          b_d   = {b_q[6:0], ui_in[2]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_ENC;
        end
        S_ENC: begin
          out_d   = cipher;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cnt_q   <= 3'd0;
      out_q   <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SERIAL_TX_EN
  logic [7:0] tx_q, tx_d;
  logic [3:0] txn_q, txn_d;
  logic       ser_q, ser_d;

  always_comb begin
    tx_d  = tx_q;
    txn_d = txn_q;
    ser_d = ser_q;
    if (ena) begin
      ser_d = 1'b0;
      case (state_q)
        S_ENC: begin
          tx_d  = cipher;
          txn_d = 4'd8;
        end
        S_DONE: begin
          if (start) begin
            txn_d = 4'd0;
          end else if (txn_q != 4'd0) begin
            ser_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
            txn_d = txn_q - 4'd1;
          end
        end
        default: txn_d = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q  <= 8'h00;
      txn_q <= 4'd0;
      ser_q <= 1'b0;
    end else begin
      tx_q  <= tx_d;
      txn_q <= txn_d;
      ser_q <= ser_d;
    end
  end

  assign ser_bit = ser_q;
  assign uio_oe  = 8'b0000_0111;
`else
  assign ser_bit = 1'b0;
  assign uio_oe  = 8'b0000_0101;
`endif

  assign uo_out  = out_q;
  assign uio_out = {5'b00000, busy_q, ser_bit, done_q};

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_secure_serdes_encryptor.sv
// Randomized directed bench for secure_serdes_encryptor.
// Reference cipher is computed arithmetically; honours SERIAL_TX_EN.
module tb_secure_serdes_encryptor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] last_out;

  secure_serdes_encryptor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_TX_EN
  localparam logic [7:0] OE_EXP = 8'h07;
`else
  localparam logic [7:0] OE_EXP = 8'h05;
`endif

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
    int x, s, r;
    x = a ^ b;
    s = b % 8;
    r = ((x << s) | (x >> (8 - s))) % 256;
    return 8'((r + b) % 256);
  endfunction

  function automatic logic [7:0] uio_exp(input logic done, input logic ser, input logic busy);
    return {5'b00000, busy, ser, done};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ab, input logic bb);
    logic [4:0] junk;
    junk   = 5'($urandom());
    ui_in  = {junk, bb, ab, st};
    uio_in = 8'($urandom());
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic hold, input int stall_at, input int stall_len);
    logic [7:0] exp;
    exp = model(a, b);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("e0_uio", uio_out, uio_exp(1'b0, 1'b0, 1'b1));
    chk("e0_out_hold", uo_out, last_out);
    for (int i = 0; i < 8; i++) begin
      drive(hold, a[7-i], b[7-i]);
      if (i == stall_at) begin
        ena = 1'b0;
        repeat (stall_len) @(negedge clk);
        chk("stall_uio", uio_out, uio_exp(1'b0, 1'b0, 1'b1));
        ena = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("shift%0d_uio", i), uio_out, uio_exp(1'b0, 1'b0, 1'b1));
    end
    drive(hold, 1'b0, 1'b0);
    @(negedge clk);
    chk($sformatf("cipher_%02h_%02h", a, b), uo_out, exp);
    chk("e9_uio", uio_out, uio_exp(1'b1, 1'b0, 1'b0));
    last_out = exp;
    if (hold) begin
      @(negedge clk);
      chk("restart_uio", uio_out, uio_exp(1'b0, 1'b0, 1'b1));
      chk("restart_out", uo_out, last_out);
      drive(1'b0, 1'b0, 1'b0);
    end else begin
`ifdef SERIAL_TX_EN
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk($sformatf("tx%0d", k), uio_out, uio_exp(1'b1, exp[7-k], 1'b0));
      end
`endif
      @(negedge clk);
      chk("done_hold_uio", uio_out, uio_exp(1'b1, 1'b0, 1'b0));
      chk("done_hold_out", uo_out, last_out);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    last_out = 8'h00;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, OE_EXP);
    rst_n = 1'b1;

    frame(8'h02, 8'h03, 1'b0, -1, 0);
    frame(8'hC3, 8'h5A, 1'b0, -1, 0);
    frame(8'hFF, 8'h07, 1'b0, -1, 0);
    frame(8'h00, 8'h00, 1'b0, -1, 0);
    frame(8'hA5, 8'h3C, 1'b0, 3, 3);
    for (int n = 0; n < 6; n++)
      frame(8'($urandom()), 8'($urandom()), 1'b0, -1, 0);

    frame(8'h5E, 8'h91, 1'b1, -1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", uo_out, 8'h00);
    chk("rst_mid_uio", uio_out, 8'h00);
    rst_n    = 1'b1;
    last_out = 8'h00;

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    ena   = 1'b0;
    @(negedge clk);
    chk("abort_out", uo_out, 8'h00);
    chk("abort_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    ena   = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    frame(8'h02, 8'h03, 1'b0, -1, 0);
    chk("final_oe", uio_oe, OE_EXP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
